// File: rtl/reg_reader_pkg.sv
// reg_reader_pkg: register-file constants shared by the read and write-back sides
package reg_reader_pkg;
    localparam int DATA_W = 32;
    localparam int NREG = 8;
    localparam logic [2:0] REG_EAX = 3'd0;
    localparam logic [2:0] REG_ECX = 3'd1;
    localparam logic [2:0] REG_EDX = 3'd2;
    localparam logic [2:0] REG_EBX = 3'd3;
    localparam logic [2:0] REG_ESP = 3'd4;
    localparam logic [2:0] REG_EBP = 3'd5;
    localparam logic [2:0] REG_ESI = 3'd6;
    localparam logic [2:0] REG_EDI = 3'd7;
endpackage

// File: rtl/reg_reader_src_forward.sv
// src_forward: one operand select with E-over-M write-back bypass
module src_forward
    import reg_reader_pkg::*;
#(
    parameter int DATA_W = reg_reader_pkg::DATA_W
) (
    input  logic              req,
    input  logic [2:0]        src,
    input  logic              reqE,
    input  logic [2:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic              reqM,
    input  logic [2:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic [DATA_W-1:0] q [NREG],
    output logic [DATA_W-1:0] val
);
    assign val = !req                 ? '0   :
                 (reqE && dstE == src) ? valE :
                 (reqM && dstM == src) ? valM : q[src];
endmodule

// File: rtl/reg_reader.sv
// reg_reader: operand fetch with bypass, load-use stall and a valid/ready output slot
module reg_reader
    import reg_reader_pkg::*;
#(
    parameter int DATA_W = reg_reader_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        srcA,
    input  logic              reqA,
    input  logic [2:0]        srcB,
    input  logic              reqB,
    input  logic [DATA_W-1:0] q_0,
    input  logic [DATA_W-1:0] q_1,
    input  logic [DATA_W-1:0] q_2,
    input  logic [DATA_W-1:0] q_3,
    input  logic [DATA_W-1:0] q_4,
    input  logic [DATA_W-1:0] q_5,
    input  logic [DATA_W-1:0] q_6,
    input  logic [DATA_W-1:0] q_7,
    input  logic [2:0]        dstE,
    input  logic              reqE,
    input  logic [DATA_W-1:0] valE,
    input  logic [2:0]        dstM,
    input  logic              reqM,
    input  logic [DATA_W-1:0] valM,
    input  logic [2:0]        ex_dst,
    input  logic              ex_load,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic [DATA_W-1:0] q [NREG];
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic hazard, accept;
    assign q = '{q_0, q_1, q_2, q_3, q_4, q_5, q_6, q_7};
    src_forward #(.DATA_W(DATA_W)) u_fwd_a (
        .req(reqA), .src(srcA), .reqE(reqE), .dstE(dstE), .valE(valE),
        .reqM(reqM), .dstM(dstM), .valM(valM), .q(q), .val(fwd_a)
    );
    src_forward #(.DATA_W(DATA_W)) u_fwd_b (
        .req(reqB), .src(srcB), .reqE(reqE), .dstE(dstE), .valE(valE),
        .reqM(reqM), .dstM(dstM), .valM(valM), .q(q), .val(fwd_b)
    );
    assign hazard = ex_load & ((reqA & (ex_dst == srcA)) | (reqB & (ex_dst == srcB)));
    assign in_ready = !hazard & (!out_valid | out_ready);
    assign accept = in_valid & in_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            valA <= '0;
            valB <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                valA <= fwd_a;
                valB <= fwd_b;
            end
            out_valid <= !flush & (accept | (out_valid & !out_ready));
            if (in_valid && hazard && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/reg_reader.md
Name: reg_reader

Overview:
- Read-side counterpart of the register write-back decoder.
- Selects operands A and B from the eight 32-bit architectural registers (q_0..q_7). Applies same-cycle bypass from the E and M write-back ports.
- Stalls on a load-use hazard and registers the operands into a valid/ready decode-to-execute pipeline slot.
- Sits between the instruction decoder and the execute stage.

Parameters:
- DATA_W, 32, register and operand width
- CNT_W, 16, width of the saturating hazard-stall counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  decoder presents operand request
- in_ready  output  1  request accepted this cycle when high together with in_valid
- srcA  input  3  register index for operand A
- reqA  input  1  operand A required
- srcB  input  3  register index for operand B
- reqB  input  1  operand B required
- q_0 .. q_7  input  DATA_W each  current register contents
- dstE  input  3  write-back E destination (same signal the writer sees)
- reqE  input  1  write-back E active
- valE  input  DATA_W  write-back E data
- dstM  input  3  write-back M destination
- reqM  input  1  write-back M active
- valM  input  DATA_W  write-back M data
- ex_dst  input  3  destination of the instruction now in execute
- ex_load  input  1  instruction in execute is a load (value not yet available)
- flush  input  1  discard the pipeline slot (mispredict)
- out_valid  output  1  valA/valB hold a valid operand pair
- out_ready  input  1  execute stage consumes the slot
- valA  output  DATA_W  registered operand A
- valB  output  DATA_W  registered operand B
- stall_cnt  output  CNT_W  count of hazard-stall cycles, saturating

Behaviour:
- Reset values: out_valid=0, valA=0, valB=0, stall_cnt=0. Reset during a held slot drops the slot.
- Operand select, per operand X:
  - If reqX=0, the value is 0.
  - Else if reqE and dstE==srcX, the value is valE.
  - Else if reqM and dstM==srcX, the value is valM.
  - Else the value is q_srcX.
- The E-over-M priority matches the write-back rule, so a register written by both ports resolves to valE.
- hazard = ex_load & ((reqA & ex_dst==srcA) | (reqB & ex_dst==srcB)).
- in_ready = !hazard & (!out_valid | out_ready). This is combinational and has no dependency on in_valid.
- Accept (in_valid & in_ready): valA/valB are captured at that edge and out_valid=1 next cycle. Latency is 1 cycle.
- Hold: when out_valid & !out_ready, valA/valB/out_valid stay stable. Later register writes do not alter the held values.
- Drain: when out_valid & out_ready & no accept, out_valid=0 next cycle. Simultaneous drain and accept gives back-to-back throughput of 1 per cycle.
- Flush: out_valid=0 next cycle. Flush overrides a same-cycle accept, and the accepted request is discarded. valA/valB may keep stale data.
- stall_cnt increments by 1 on each cycle with in_valid & hazard. It saturates at 2^CNT_W-1 and is cleared only by reset.
- A hazard with in_valid=0 does not count.
- A hazard with a request that has reqA=reqB=0 cannot occur by definition.

Decomposition:
- Shared package (also imported by the write-back decoder):
  - DATA_W.
  - NREG=8.
  - Register index constants REG_EAX=0, REG_ECX=1, REG_EDX=2, REG_EBX=3, REG_ESP=4, REG_EBP=5, REG_ESI=6, REG_EDI=7.
- Sub-module src_forward: the combinational per-operand select (req/src/E/M/q array to value). Instantiated twice, for A and B.
- The top level holds the handshake, the hazard logic, the slot registers and the counter.

Test Plan:
- Plain read: q_3=0x1234, srcA=3 reqA=1, reqB=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, valA=0x1234, valB=0.
- Bypass priority: srcA=srcB=5, q_5=0x1, reqE=1 dstE=5 valE=0xAAAA, reqM=1 dstM=5 valM=0xBBBB -> valA=valB=0xAAAA. Repeat with reqE=0 -> valA=valB=0xBBBB.
- Load-use stall: ex_load=1 ex_dst=2, srcB=2 reqB=1, in_valid held for 3 cycles -> in_ready=0 for those 3 cycles and stall_cnt=3. Drop ex_load -> accept next edge, out_valid=1 one cycle later.
- Backpressure: accept valA=0x10, then out_ready=0 for 4 cycles while q_ and valE change -> valA stays 0x10, in_ready=0. Then out_ready=1 with a new request -> slot replaced in one cycle, no bubble.
- Flush vs accept: in_valid=1, in_ready=1 and flush=1 in the same cycle -> out_valid=0 next cycle. stall_cnt is unchanged.
- Reset mid-hold: out_valid=1, out_ready=0, stall_cnt=7, reset=1 for one cycle -> out_valid=0, valA=valB=0, stall_cnt=0 after the edge.
